// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared encodings for the mem_io_bus interconnect
package bus_pkg;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_ERR   = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RAM_RD = 2'd1;
   localparam logic [1:0] ST_ACK    = 2'd2;

   typedef enum logic [1:0] {
      SEL_RAM,
      SEL_LED,
      SEL_SW,
      SEL_NONE
   } sel_e;

endpackage

// File: rtl/mem_io_bus_if.sv
// rtl/mem_io_bus_if.sv - CPU memory port bundle with cpu (master) and bus (slave) views
interface mem_io_bus_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9
);
   logic [1:0]        mem_cmd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic              mem_ready;

   modport master (
      output mem_cmd, mem_addr, write_data,
      input  read_data, mem_ready
   );

   modport slave (
      input  mem_cmd, mem_addr, write_data,
      output read_data, mem_ready
   );
endinterface

// File: rtl/bus_ram.sv
// rtl/bus_ram.sv - single-port RAM, synchronous write, one-cycle registered read
module bus_ram #(
   parameter int DATA_W = 16,
   parameter int RAM_AW = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [RAM_AW-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [0:(1<<RAM_AW)-1];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end
endmodule

// File: rtl/mem_io_bus.sv
// rtl/mem_io_bus.sv - CPU port to RAM/LED/switch interconnect; BUS_ERR_EN adds sticky bus_err
module mem_io_bus
   import bus_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 9,
   parameter int                RAM_AW   = 8,
   parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
   parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140,
   parameter int                LED_W    = 8,
   parameter int                SW_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   mem_io_bus_if.slave      bus,
   input  logic [SW_W-1:0]  sw_in,
   output logic [LED_W-1:0] led_out
`ifdef BUS_ERR_EN
   ,
   output logic             bus_err
`endif
);
   logic [1:0]        state;
   logic [DATA_W-1:0] read_q;
   logic [DATA_W-1:0] ram_rdata;
   logic [SW_W-1:0]   sw_meta;
   logic [SW_W-1:0]   sw_sync;
   logic              is_read;
   logic              is_write;
   logic              ram_we;
   sel_e              sel;

   always_comb begin
      sel = SEL_NONE;
      // RAM owns every address whose bits above the RAM index are all zero.
      if ((bus.mem_addr >> RAM_AW) == '0) begin
         sel = SEL_RAM;
      end else if (bus.mem_addr == LED_ADDR) begin
         sel = SEL_LED;
      end else if (bus.mem_addr == SW_ADDR) begin
         sel = SEL_SW;
      end
   end

   assign is_read  = (bus.mem_cmd == CMD_READ);
   assign is_write = (bus.mem_cmd == CMD_WRITE);
   assign ram_we   = !reset && (state == ST_IDLE) && is_write && (sel == SEL_RAM);

   assign bus.mem_ready = !reset && (state == ST_ACK);
   assign bus.read_data = read_q;

   bus_ram #(
      .DATA_W (DATA_W),
      .RAM_AW (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (bus.mem_addr[RAM_AW-1:0]),
      .wdata (bus.write_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         read_q  <= '0;
         led_out <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
`ifdef BUS_ERR_EN
         bus_err <= 1'b0;
`endif
      end else begin
         sw_meta <= sw_in;
         sw_sync <= sw_meta;
         case (state)
            ST_IDLE: begin
               if (is_read) begin
                  state <= ST_ACK;
                  case (sel)
                     SEL_RAM:  state  <= ST_RAM_RD;
                     SEL_LED:  read_q <= DATA_W'(led_out);
                     SEL_SW:   read_q <= DATA_W'(sw_sync);
                     default:  read_q <= '0;
                  endcase
               end else if (is_write) begin
                  state <= ST_ACK;
                  if (sel == SEL_LED) begin
                     led_out <= bus.write_data[LED_W-1:0];
                  end
               end
`ifdef BUS_ERR_EN
               if (bus.mem_cmd == CMD_ERR) begin
                  state <= ST_ACK;
               end
               // Flag becomes visible in the ACK cycle of the failing access.
               if ((bus.mem_cmd == CMD_ERR) || ((is_read || is_write) && (sel == SEL_NONE))) begin
                  bus_err <= 1'b1;
               end
`endif
            end
            ST_RAM_RD: begin
               read_q <= ram_rdata;
               state  <= ST_ACK;
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
